// File: rtl/a1csa_pkg.sv
// Shared constants and sizing helpers for the add-one carry-select adder family.
package a1csa_pkg;

   localparam int unsigned DefN    = 32;
   localparam int unsigned DefSegW = 8;

   // Pipeline depth for a given operand width and segment width.
   function automatic int unsigned num_stages(input int unsigned n, input int unsigned seg_w);
      return (seg_w == 0) ? 1 : n / seg_w;
   endfunction

   // A legal split is a non-empty segment that tiles the operand exactly.
   function automatic bit seg_cfg_ok(input int unsigned n, input int unsigned seg_w);
      return (seg_w >= 1) && (n >= seg_w) && ((n % ((seg_w == 0) ? 1 : seg_w)) == 0);
   endfunction

endpackage

// File: rtl/a1csa_seg.sv
// One carry-select segment: sums for carry-in 0 and 1 plus segment generate/propagate.
module a1csa_seg #(
   parameter int unsigned SEG_W = 8
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   output logic [SEG_W-1:0] sum0,
   output logic [SEG_W-1:0] sum1,
   output logic             g,
   output logic             p
);

   // sum1 is derived from sum0 by an incrementer rather than a second full adder.
   always_comb begin
      {g, sum0} = {1'b0, a} + {1'b0, b};
      sum1      = sum0 + SEG_W'(1);
      p         = &(a ^ b);
   end

endmodule

// File: rtl/a1csah_pipe.sv
// Pipelined add-one carry-select adder, one segment resolved per stage, valid/ready stream.
module a1csah_pipe
   import a1csa_pkg::*;
#(
   parameter int unsigned N     = DefN,
   parameter int unsigned SEG_W = DefSegW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         cin,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         gen,
   output logic         prop
);

   localparam int unsigned STAGES = num_stages(N, SEG_W);

   if (!seg_cfg_ok(N, SEG_W)) begin : g_cfg_err
      $error("a1csah_pipe: N must be a non-zero exact multiple of SEG_W");
   end

   logic              adv;
   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] valid_q;

   assign out_valid = valid_q[STAGES-1];

   // Global stall: the whole pipe moves only when the output slot is free or being taken.
   always_comb begin
      adv        = ~out_valid | out_ready;
      in_ready   = adv & ~rst;
      valid_d    = '0;
      valid_d[0] = in_valid & in_ready;
      for (int k = 1; k < int'(STAGES); k++) begin
         valid_d[k] = valid_q[k-1];
      end
   end

   // Valid shift register; bubbles advance too, so no collapse.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (adv) begin
         valid_q <= valid_d;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned SumW = (k + 1) * SEG_W;
      localparam int unsigned RemW = N - SumW;

      logic [SEG_W-1:0] seg_a;
      logic [SEG_W-1:0] seg_b;
      logic [SEG_W-1:0] sum0;
      logic [SEG_W-1:0] sum1;
      logic             g;
      logic             p;
      logic             sel;
      logic             gen_in;
      logic             prop_in;
      logic [SumW-1:0]  sum_d;
      logic [SumW-1:0]  sum_q;
      logic             carry_q;
      logic             gen_q;
      logic             prop_q;
      logic             ld;

      // Data registers load only for a valid token, so bubbles leave them untouched.
      assign ld = adv & valid_d[k];

      if (k == 0) begin : g_first
         assign seg_a   = a[SEG_W-1:0];
         assign seg_b   = b[SEG_W-1:0];
         assign sel     = cin;
         assign gen_in  = 1'b0;
         assign prop_in = 1'b1;
         assign sum_d   = sel ? sum1 : sum0;
      end else begin : g_next
         assign seg_a   = g_stage[k-1].g_rem.a_q[SEG_W-1:0];
         assign seg_b   = g_stage[k-1].g_rem.b_q[SEG_W-1:0];
         assign sel     = g_stage[k-1].carry_q;
         assign gen_in  = g_stage[k-1].gen_q;
         assign prop_in = g_stage[k-1].prop_q;
         assign sum_d   = {(sel ? sum1 : sum0), g_stage[k-1].sum_q};
      end

      a1csa_seg #(
         .SEG_W(SEG_W)
      ) u_seg (
         .a    (seg_a),
         .b    (seg_b),
         .sum0 (sum0),
         .sum1 (sum1),
         .g    (g),
         .p    (p)
      );

      // Segment result, running carry and group generate/propagate for this stage.
      always_ff @(posedge clk) begin
         if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            gen_q   <= 1'b0;
            prop_q  <= 1'b0;
         end else if (ld) begin
            sum_q   <= sum_d;
            carry_q <= g | (p & sel);
            gen_q   <= g | (p & gen_in);
            prop_q  <= p & prop_in;
         end
      end

      // Operand bits not yet consumed; the last stage carries none.
      if (RemW > 0) begin : g_rem
         logic [RemW-1:0] a_d;
         logic [RemW-1:0] b_d;
         logic [RemW-1:0] a_q;
         logic [RemW-1:0] b_q;

         if (k == 0) begin : g_src_in
            assign a_d = a[N-1:SEG_W];
            assign b_d = b[N-1:SEG_W];
         end else begin : g_src_prev
            assign a_d = g_stage[k-1].g_rem.a_q[RemW+SEG_W-1:SEG_W];
            assign b_d = g_stage[k-1].g_rem.b_q[RemW+SEG_W-1:SEG_W];
         end

         // Pure data pipe; contents are meaningful only alongside a valid token.
         always_ff @(posedge clk) begin
            if (ld) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end
   end

   assign s    = g_stage[STAGES-1].sum_q;
   assign cout = g_stage[STAGES-1].carry_q;
   assign gen  = g_stage[STAGES-1].gen_q;
   assign prop = g_stage[STAGES-1].prop_q;

endmodule
